// File: rtl/pack_i64_stream_if.sv
// rtl/pack_i64_stream_if.sv - value-in / LEB128-byte-out stream bundle for pack_i64_stream
//
// Signals:
//   in_data   [63:0] signed value offered to the encoder
//   in_valid         in_data presented
//   in_ready         encoder can accept a value this cycle
//   out_byte  [7:0]  signed-LEB128 byte, bit 7 = continuation
//   out_valid        out_byte is valid
//   out_ready        sink accepts out_byte this cycle
//   out_last         out_byte is the final byte of the value
//   out_idx   [3:0]  byte index within the value (0..9)
// Modports: master = value source / byte sink side, slave = encoder side.

interface pack_i64_stream_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [3:0]  out_idx;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_last, out_idx
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_last, out_idx
    );
endinterface

// File: rtl/pack_i64_stream.sv
// rtl/pack_i64_stream.sv - signed 64-bit to signed-LEB128 byte stream encoder
//
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  pack_i64_stream_if.slave: value in (in_data/in_valid/in_ready),
//        bytes out (out_byte/out_valid/out_ready/out_last/out_idx)
//
// One value is held at a time. The held value is shifted right by 7 after
// each accepted byte; the final byte's handshake cycle can accept the next
// value so consecutive values stream without a bubble.

module pack_i64_stream (
    input  logic             clk,
    input  logic             rst,
    pack_i64_stream_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic signed [63:0] val;
    logic signed [63:0] val_nx;
    logic [3:0]         idx;
    logic [3:0]         idx_nx;

    logic               fin;
    logic               send;
    logic               ready;
    logic [56:0]        rest;

    // rest is the held value arithmetically shifted right by 7. The byte is
    // final once the remaining bits are pure sign extension of payload bit 6;
    // the 10th byte always qualifies but is forced for safety.
    assign rest = val[63:7];
    assign fin  = (idx == 4'd9)
               || ((rest == '0) && !val[6])
               || ((rest == '1) &&  val[6]);
    assign send = (state == SEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= '0;
            idx <= '0;
        end else begin
            val <= val_nx;
            idx <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        val_nx   = val;
        idx_nx   = idx;
        ready    = 1'b0;
        if (state == IDLE) begin
            ready = 1'b1;
            if (bus.in_valid) begin
                state_nx = SEND;
                val_nx   = bus.in_data;
                idx_nx   = 4'd0;
            end
        end else begin
            if (bus.out_ready) begin
                if (!fin) begin
                    val_nx = {{7{val[63]}}, val[63:7]};
                    idx_nx = idx + 4'd1;
                end else begin
                    // Final byte leaving: a new value may slip in this cycle.
                    ready = 1'b1;
                    if (bus.in_valid) begin
                        val_nx = bus.in_data;
                        idx_nx = 4'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        end
    end

    // Byte-side outputs depend only on registered state; zeroed when idle.
    assign bus.in_ready  = ready;
    assign bus.out_valid = send;
    assign bus.out_last  = send & fin;
    assign bus.out_byte  = send ? {~fin, val[6:0]} : 8'h00;
    assign bus.out_idx   = send ? idx : 4'd0;

endmodule

// File: tb/tb_pack_i64_stream.sv
// tb/tb_pack_i64_stream.sv - self-checking bench for pack_i64_stream

module tb_pack_i64_stream;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic [3:0] idx;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    pack_i64_stream_if bus ();

    pack_i64_stream dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: 7 payload bits per byte, stop once the remainder is
    // pure sign extension of payload bit 6.
    function automatic void push_model(input logic [63:0] v);
        logic signed [63:0] r;
        logic [6:0]         p;
        logic               f;
        r = v;
        for (int i = 0; i < 10; i++) begin
            p = r[6:0];
            r = r >>> 7;
            f = (i == 9) || ((r == 64'sd0) && !p[6]) || ((r == -64'sd1) && p[6]);
            exp_q.push_back({!f, p, f, 4'(i)});
            if (f) break;
        end
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_byte, bus.out_idx} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b l=%b b=%h i=%0d exp all zero",
                     bus.out_valid, bus.out_last, bus.out_byte, bus.out_idx);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got in_ready=%b out_valid=%b exp 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_single_byte;
        logic [63:0] vals[$];
        exp_t        e;
        int          cyc;
        vals = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd63, 64'hFFFF_FFFF_FFFF_FFC0};
        exp_q.push_back({8'h01, 1'b1, 4'd0});
        exp_q.push_back({8'h7F, 1'b1, 4'd0});
        exp_q.push_back({8'h05, 1'b1, 4'd0});
        exp_q.push_back({8'h3F, 1'b1, 4'd0});
        exp_q.push_back({8'h40, 1'b1, 4'd0});
        cyc = 0;
        while ((vals.size() != 0 || exp_q.size() != 0) && cyc < 200) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : {$urandom, $urandom};
            bus.out_ready = 1'b1;
            #1;
            if (!bus.out_valid && bus.out_last) begin
                checks++; failures++;
                $display("FAIL single_last_idle out_last=1 with out_valid=0");
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL single_extra got=%h exp none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_byte, bus.out_last, bus.out_idx} !== e) begin
                        failures++;
                        $display("FAIL single_byte got b=%h l=%b i=%0d exp b=%h l=%b i=%0d",
                                 bus.out_byte, bus.out_last, bus.out_idx, e.b, e.last, e.idx);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (vals.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_timeout got left=%0d exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_multi_byte;
        logic [63:0] vals[$];
        exp_t        e;
        int          cyc;
        int          last_hs;
        vals = '{64'h0000_0000_C000_0000, 64'd64, 64'hFFFF_FFFF_FFFF_FFBF};
        exp_q.push_back({8'h80, 1'b0, 4'd0});
        exp_q.push_back({8'h80, 1'b0, 4'd1});
        exp_q.push_back({8'h80, 1'b0, 4'd2});
        exp_q.push_back({8'h80, 1'b0, 4'd3});
        exp_q.push_back({8'h0C, 1'b1, 4'd4});
        exp_q.push_back({8'hC0, 1'b0, 4'd0});
        exp_q.push_back({8'h00, 1'b1, 4'd1});
        exp_q.push_back({8'hBF, 1'b0, 4'd0});
        exp_q.push_back({8'h7F, 1'b1, 4'd1});
        cyc = 0;
        last_hs = -10;
        while ((vals.size() != 0 || exp_q.size() != 0) && cyc < 200) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : {$urandom, $urandom};
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL multi_extra got=%h exp none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_byte, bus.out_last, bus.out_idx} !== e) begin
                        failures++;
                        $display("FAIL multi_byte got b=%h l=%b i=%0d exp b=%h l=%b i=%0d",
                                 bus.out_byte, bus.out_last, bus.out_idx, e.b, e.last, e.idx);
                    end
                    if (e.idx != 4'd0) begin
                        checks++;
                        if (cyc != last_hs + 1) begin
                            failures++;
                            $display("FAIL multi_gap got gap=%0d exp 1", cyc - last_hs);
                        end
                    end
                end
                last_hs = cyc;
            end
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (vals.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL multi_timeout got left=%0d exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_max_length;
        logic [63:0] vals[$];
        logic [63:0] v;
        exp_t        e;
        int          cyc;
        vals = '{64'h8000_0000_0000_0000};
        for (int i = 0; i < 9; i++) exp_q.push_back({8'h80, 1'b0, 4'(i)});
        exp_q.push_back({8'h7F, 1'b1, 4'd9});
        for (int i = 0; i < 6; i++) begin
            v = $signed({$urandom, $urandom}) >>> $urandom_range(0, 62);
            vals.push_back(v);
            push_model(v);
        end
        vals.push_back(64'h7FFF_FFFF_FFFF_FFFF);
        push_model(64'h7FFF_FFFF_FFFF_FFFF);
        cyc = 0;
        while ((vals.size() != 0 || exp_q.size() != 0) && cyc < 400) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : {$urandom, $urandom};
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL long_extra got=%h exp none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_byte, bus.out_last, bus.out_idx} !== e) begin
                        failures++;
                        $display("FAIL long_byte got b=%h l=%b i=%0d exp b=%h l=%b i=%0d",
                                 bus.out_byte, bus.out_last, bus.out_idx, e.b, e.last, e.idx);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (vals.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL long_timeout got left=%0d exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [63:0] vals[$];
        exp_t        e;
        int          cyc;
        int          hs_cyc[$];
        vals = '{64'd1, 64'd2};
        exp_q.push_back({8'h01, 1'b1, 4'd0});
        exp_q.push_back({8'h02, 1'b1, 4'd0});
        cyc = 0;
        while ((vals.size() != 0 || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : {$urandom, $urandom};
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra got=%h exp none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_byte, bus.out_last, bus.out_idx} !== e) begin
                        failures++;
                        $display("FAIL b2b_byte got b=%h l=%b i=%0d exp b=%h l=%b i=%0d",
                                 bus.out_byte, bus.out_last, bus.out_idx, e.b, e.last, e.idx);
                    end
                    if (e.b == 8'h01) begin
                        checks++;
                        if (bus.in_ready !== 1'b1) begin
                            failures++;
                            $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready);
                        end
                    end
                end
                hs_cyc.push_back(cyc);
            end
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (hs_cyc.size() != 2 || hs_cyc[1] != hs_cyc[0] + 1) begin
            failures++;
            $display("FAIL b2b_adjacent got handshakes=%0d exp 2 on adjacent cycles", hs_cyc.size());
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure;
        logic [63:0] vals[$];
        exp_t        e;
        int          cyc;
        logic        stall;
        logic [12:0] held;
        logic        exp_ir;
        vals = '{64'd300};
        exp_q.push_back({8'hAC, 1'b0, 4'd0});
        exp_q.push_back({8'h02, 1'b1, 4'd0 + 4'd1});
        cyc = 0;
        stall = 1'b0;
        held = '0;
        while ((vals.size() != 0 || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : {$urandom, $urandom};
            bus.out_ready = cyc[0];
            #1;
            if (stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.out_byte, bus.out_last, bus.out_idx} !== held) begin
                    failures++;
                    $display("FAIL bp_stable got v=%b bli=%h exp v=1 bli=%h",
                             bus.out_valid, {bus.out_byte, bus.out_last, bus.out_idx}, held);
                end
            end
            if (bus.out_valid && exp_q.size() != 0) begin
                exp_ir = bus.out_ready && exp_q[0].last;
                checks++;
                if (bus.in_ready !== exp_ir) begin
                    failures++;
                    $display("FAIL bp_in_ready got=%b exp=%b", bus.in_ready, exp_ir);
                end
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = {bus.out_byte, bus.out_last, bus.out_idx};
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got=%h exp none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_byte, bus.out_last, bus.out_idx} !== e) begin
                        failures++;
                        $display("FAIL bp_byte got b=%h l=%b i=%0d exp b=%h l=%b i=%0d",
                                 bus.out_byte, bus.out_last, bus.out_idx, e.b, e.last, e.idx);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (vals.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout got left=%0d exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [63:0] vals[$];
        exp_t        e;
        int          cyc;
        logic        seen;
        vals = '{64'h0000_0000_C000_0000};
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : 64'h0;
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready && bus.out_byte == 8'h80 && bus.out_idx == 4'd0)
                seen = 1'b1;
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rstmid_first got no 80/idx0 byte exp one");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_byte, bus.out_idx} !== 14'h0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async got v=%b l=%b b=%h i=%0d r=%b exp 0/0/00/0/1",
                     bus.out_valid, bus.out_last, bus.out_byte, bus.out_idx, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release got in_ready=%b out_valid=%b exp 1/0",
                     bus.in_ready, bus.out_valid);
        end
        vals = '{64'd5};
        exp_q.delete();
        exp_q.push_back({8'h05, 1'b1, 4'd0});
        cyc = 0;
        while ((vals.size() != 0 || exp_q.size() != 0) && cyc < 20) begin
            @(negedge clk);
            bus.in_valid  = (vals.size() != 0);
            bus.in_data   = (vals.size() != 0) ? vals[0] : {$urandom, $urandom};
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rstmid_extra got=%h exp none", bus.out_byte);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_byte, bus.out_last, bus.out_idx} !== e) begin
                        failures++;
                        $display("FAIL rstmid_byte got b=%h l=%b i=%0d exp b=%h l=%b i=%0d",
                                 bus.out_byte, bus.out_last, bus.out_idx, e.b, e.last, e.idx);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) void'(vals.pop_front());
            cyc++;
        end
        checks++;
        if (vals.size() != 0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_timeout got left=%0d exp 0", exp_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_trailing got out_valid=%b b=%h exp 0", bus.out_valid, bus.out_byte);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_byte();
        test_multi_byte();
        test_max_length();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pack_i64_stream.md
PACK_I64_STREAM -- requirements
Module: pack_i64_stream

Interface
REQ-001 SHALL have no parameters; data widths are fixed at 64-bit input and 8-bit output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_data  input  64  signed two's-complement value to encode.
REQ-005 in_valid  input  1  in_data presented.
REQ-006 in_ready  output  1  encoder can accept a value this cycle.
REQ-007 out_byte  output  8  current signed-LEB128 byte; bit 7 is the continuation flag.
REQ-008 out_valid  output  1  out_byte is valid.
REQ-009 out_ready  input  1  sink accepts out_byte this cycle.
REQ-010 out_last  output  1  out_byte is the final byte of the current value.
REQ-011 out_idx  output  4  zero-based index of out_byte within the current value (0..9).

Function
REQ-012 SHALL encode each accepted value as signed LEB128, emitting 7 payload bits per byte, LSB group first.
REQ-013 SHALL treat a byte as final when the remaining value, arithmetically shifted right by 7, is 0 with payload bit 6 = 0, or is -1 with payload bit 6 = 1.
REQ-014 SHALL set out_byte[7] = 0 on the final byte and 1 on all other bytes.
REQ-015 SHALL emit between 1 and 10 bytes per value; the 10th byte, if reached, is always final.
REQ-016 SHALL use two states: IDLE (no value held) and SEND (value held, out_valid = 1).
REQ-017 IDLE -> SEND SHALL occur on the cycle in_valid && in_ready; the first byte SHALL appear with out_valid = 1 on the following cycle (1-cycle latency).
REQ-018 In SEND, on out_valid && out_ready && !out_last: SHALL shift the held value arithmetically right by 7 and increment out_idx.
REQ-019 In SEND, on out_valid && out_ready && out_last: SHALL return to IDLE, unless a new value is accepted in the same cycle (REQ-021), in which case SHALL remain in SEND with out_idx = 0.
REQ-020 in_ready SHALL be 1 in IDLE, and in SEND only in a cycle where out_valid && out_ready && out_last; otherwise 0. in_ready SHALL NOT depend on in_valid.
REQ-021 Back-to-back values SHALL stream with no idle cycle between the last byte of one value and the first byte of the next.
REQ-022 While out_valid && !out_ready, out_byte, out_last and out_idx SHALL hold stable.
REQ-023 out_valid SHALL NOT drop without a completed handshake.
REQ-024 out_last SHALL be 0 whenever out_valid = 0.
REQ-025 in_data SHALL be sampled only on an accept cycle; later changes to in_data SHALL have no effect on the value in flight.
REQ-026 All outputs except in_ready SHALL be functions of registered state only; there SHALL be no combinational path from in_data to out_*.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE, independent of clk.
REQ-028 Reset values SHALL be: out_valid = 0, out_last = 0, out_byte = 8'h00, out_idx = 0, held value = 0.
REQ-029 in_ready SHALL be 1 while rst is asserted and on the first cycle after release.
REQ-030 Reset asserted mid-value SHALL abandon the remaining bytes; no partial byte SHALL appear after reset is released.

Verification
REQ-031 Send 1 with out_ready = 1 -> single byte 0x01, out_last = 1, out_idx = 0; send -1 -> single byte 0x7F, out_last = 1.
REQ-032 Send 64'h00000000C0000000 -> bytes 80 80 80 80 0C on consecutive cycles, out_idx 0..4, out_last only on 0x0C.
REQ-033 Send 64 -> bytes C0 00; send -65 -> bytes BF 7F; send 64'h8000000000000000 -> 80 ×9 then 7F, 10 bytes total.
REQ-034 Send 1, then 2, with in_valid held and out_ready = 1 -> 01 then 02 on adjacent cycles, with in_ready = 1 on the 0x01 cycle.
REQ-035 Send 300 (bytes AC 02) with out_ready toggled 0/1 each cycle -> each byte held stable until accepted, exactly AC then 02, and in_ready = 0 until the 02 handshake.
REQ-036 Assert rst after the first byte of 64'h00000000C0000000 is accepted -> out_valid = 0 immediately; after release, send 5 -> single byte 05 with out_idx = 0.
